// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmit channel between NREQ frame sources.
// Frames go out as HDR, payload bytes (LSB first), then an 8-bit additive checksum.
module uart_tx_arbiter #(
    parameter int          NREQ = 4,
    parameter int          MAXB = 8,
    parameter int          LW   = 4,
    parameter logic [7:0]  HDR  = 8'hAA
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*LW-1:0]       frame_len_i,
    input  logic [NREQ*MAXB*8-1:0]   frame_data_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [NREQ-1:0]          done_o,
    output logic                     busy_o,
    input  logic                     tx_ready_i,
    output logic                     tx_valid_o,
    output logic [7:0]               tx_data_o
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [LW-1:0]       len_q, len_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [MAXB*8-1:0]   data_q, data_d;
    logic [7:0]          csum_q, csum_d;

    logic                found;
    logic [PW-1:0]       win;
    logic [LW-1:0]       win_len;
    logic [MAXB*8-1:0]   win_data;
    logic [7:0]          cur_byte;
    logic                xfer;

    assign xfer     = tx_valid_o && tx_ready_i;
    assign cur_byte = data_q[{idx_q, 3'b000} +: 8];
    assign grant_o  = grant_q;
    assign busy_o   = (state_q != S_IDLE);

    // Source 0 always wins; the rest rotate starting at rr_ptr_q with wrap back to 1.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_len  = '0;
        win_data = '0;
        if (req_i[0]) begin
            found = 1'b1;
        end else begin
            for (int i = 1; i < NREQ; i++) begin
                if (!found && req_i[i] && (PW'(i) >= rr_ptr_q)) begin
                    found = 1'b1;
                    win   = PW'(i);
                end
            end
            for (int i = 1; i < NREQ; i++) begin
                if (!found && req_i[i] && (PW'(i) < rr_ptr_q)) begin
                    found = 1'b1;
                    win   = PW'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                win_len  = frame_len_i[i*LW +: LW];
                win_data = frame_data_i[i*MAXB*8 +: MAXB*8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= PW'(1);
            len_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            csum_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            csum_q   <= csum_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        len_d    = len_q;
        idx_d    = idx_q;
        data_d   = data_q;
        csum_d   = csum_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_HDR;
                    grant_d = NREQ'(1) << win;
                    len_d   = (win_len > LW'(MAXB)) ? LW'(MAXB) : win_len;
                    data_d  = win_data;
                    if (win != '0) begin
                        rr_ptr_d = (win == PW'(NREQ-1)) ? PW'(1) : win + PW'(1);
                    end
                end
            end
            S_HDR: begin
                if (xfer) begin
                    state_d = (len_q != '0) ? S_DATA : S_CSUM;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q + cur_byte;
                    idx_d  = idx_q + LW'(1);
                    if (idx_q + LW'(1) == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = '0;
                csum_d  = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state only, so they hold steady through any stall.
    always_comb begin
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        done_o     = '0;
        case (state_q)
            S_HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = HDR;
            end
            S_DATA: begin
                tx_valid_o = 1'b1;
                tx_data_o  = cur_byte;
            end
            S_CSUM: begin
                tx_valid_o = 1'b1;
                tx_data_o  = csum_q;
            end
            S_DONE: done_o = grant_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: inputs change 1ns after posedge,
// a negedge monitor logs accepted bytes, done pulses and grant starts.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int MAXB = 8;
    localparam int LW   = 4;

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*LW-1:0]      frameLen;
    logic [NREQ*MAXB*8-1:0]  frameData;
    logic [NREQ-1:0]         grant;
    logic [NREQ-1:0]         done;
    logic                    busy;
    logic                    txReady;
    logic                    txValid;
    logic [7:0]              txData;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]      txq[$];
    logic [NREQ-1:0] doneq[$];
    logic [NREQ-1:0] grantq[$];
    logic [NREQ-1:0] busyGrants[$];
    logic [NREQ-1:0] prevGrant = '0;

    uart_tx_arbiter #(.NREQ(NREQ), .MAXB(MAXB), .LW(LW), .HDR(8'hAA)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .frame_len_i  (frameLen),
        .frame_data_i (frameData),
        .grant_o      (grant),
        .done_o       (done),
        .busy_o       (busy),
        .tx_ready_i   (txReady),
        .tx_valid_o   (txValid),
        .tx_data_o    (txData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle observer: a byte logged here transfers on the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (txValid && txReady) txq.push_back(txData);
            if (done != '0) doneq.push_back(done);
            if (grant != '0 && prevGrant == '0) grantq.push_back(grant);
            if (busy) busyGrants.push_back(grant);
            prevGrant = grant;
        end else begin
            prevGrant = '0;
        end
    end

    task automatic clear_logs();
        txq.delete();
        doneq.delete();
        grantq.delete();
        busyGrants.delete();
    endtask

    task automatic set_src(input int s, input logic [LW-1:0] len, input logic [63:0] bytes);
        frameLen[s*LW +: LW]          = len;
        frameData[s*MAXB*8 +: MAXB*8] = bytes;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        txReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int src);
        bit got = 1'b0;
        req[src] = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(posedge clk); #1;
            if (done[src]) begin
                got      = 1'b1;
                req[src] = 1'b0;
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            req[src] = 1'b0;
            $display("[TB] FAIL frame_done src%0d got no pulse want pulse", src);
        end
        wait_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; txReady = 1'b1; frameLen = '0; frameData = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_grant got %b want 0000", grant); end
        vectors++; if (done !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_done got %b want 0000", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
        vectors++; if (txValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid got %b want 0", txValid); end
        vectors++; if (txData !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_data got %02h want 00", txData); end
        rst = 1'b0;
        clear_logs();
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single_frame();
        logic [7:0] exp[$];
        int bad = 0;
        exp = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h66};
        set_src(2, 4'd3, 64'h332211);
        clear_logs();
        run_frame(2);
        vectors++; if (txq.size() != exp.size()) begin miscompares++; $display("[TB] FAIL t1_count got %0d want %0d", txq.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < txq.size(); k++) begin
            vectors++; if (txq[k] !== exp[k]) begin miscompares++; $display("[TB] FAIL t1_byte%0d got %02h want %02h", k, txq[k], exp[k]); end
        end
        vectors++; if (doneq.size() != 1 || doneq[0] !== 4'b0100) begin miscompares++; $display("[TB] FAIL t1_done got %0d pulses want 1 pulse of 0100", doneq.size()); end
        foreach (busyGrants[k]) if (busyGrants[k] !== 4'b0100) bad++;
        vectors++; if (busyGrants.size() != 6 || bad != 0) begin miscompares++; $display("[TB] FAIL t1_grant got %0d busy cycles %0d wrong want 6 cycles 0 wrong", busyGrants.size(), bad); end
    endtask

    task automatic test_latency_len0();
        logic [7:0] exp[$];
        exp = '{8'hAA, 8'h00};
        set_src(1, 4'd0, 64'h5A);
        clear_logs();
        req[1] = 1'b1;
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("[TB] FAIL lat_pre_grant got %b want 0000", grant); end
        @(posedge clk); #1;
        vectors++; if (grant !== 4'b0010) begin miscompares++; $display("[TB] FAIL lat_grant got %b want 0010", grant); end
        vectors++; if (txValid !== 1'b1 || txData !== 8'hAA) begin miscompares++; $display("[TB] FAIL lat_hdr got v=%b d=%02h want v=1 d=aa", txValid, txData); end
        run_frame(1);
        vectors++; if (txq.size() != 2) begin miscompares++; $display("[TB] FAIL len0_count got %0d want 2", txq.size()); end
        for (int k = 0; k < exp.size() && k < txq.size(); k++) begin
            vectors++; if (txq[k] !== exp[k]) begin miscompares++; $display("[TB] FAIL len0_byte%0d got %02h want %02h", k, txq[k], exp[k]); end
        end
    endtask

    task automatic test_checksum_clamp();
        logic [7:0] exp[$];
        exp = '{8'hAA, 8'hFF, 8'h02, 8'h01};
        set_src(1, 4'd2, 64'h02FF);
        clear_logs();
        run_frame(1);
        vectors++; if (txq.size() != exp.size()) begin miscompares++; $display("[TB] FAIL wrap_count got %0d want %0d", txq.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < txq.size(); k++) begin
            vectors++; if (txq[k] !== exp[k]) begin miscompares++; $display("[TB] FAIL wrap_byte%0d got %02h want %02h", k, txq[k], exp[k]); end
        end
        exp = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        set_src(3, 4'd15, 64'h0807060504030201);
        clear_logs();
        run_frame(3);
        vectors++; if (txq.size() != exp.size()) begin miscompares++; $display("[TB] FAIL clamp_count got %0d want %0d", txq.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < txq.size(); k++) begin
            vectors++; if (txq[k] !== exp[k]) begin miscompares++; $display("[TB] FAIL clamp_byte%0d got %02h want %02h", k, txq[k], exp[k]); end
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] expG[$];
        bit raised = 1'b0;
        expG = '{4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010};
        do_reset();
        set_src(0, 4'd1, 64'h05);
        set_src(1, 4'd1, 64'h31);
        set_src(2, 4'd1, 64'h32);
        set_src(3, 4'd1, 64'h33);
        req = 4'b1110;
        for (int c = 0; c < 300 && grantq.size() < 5; c++) begin
            @(posedge clk); #1;
            if (!raised && grantq.size() == 2) begin
                req[0] = 1'b1;
                raised = 1'b1;
            end
            if (done[0]) req[0] = 1'b0;
        end
        req = '0;
        wait_idle();
        vectors++; if (grantq.size() != expG.size()) begin miscompares++; $display("[TB] FAIL rr_count got %0d want %0d", grantq.size(), expG.size()); end
        for (int k = 0; k < expG.size() && k < grantq.size(); k++) begin
            vectors++; if (grantq[k] !== expG[k]) begin miscompares++; $display("[TB] FAIL rr_grant%0d got %b want %b", k, grantq[k], expG[k]); end
        end
        for (int k = 0; k < expG.size() && k < doneq.size(); k++) begin
            vectors++; if (doneq[k] !== expG[k]) begin miscompares++; $display("[TB] FAIL rr_done%0d got %b want %b", k, doneq[k], expG[k]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp[$];
        bit got = 1'b0;
        int bad = 0;
        logic prevValid = 1'b0, prevReady = 1'b1;
        logic [7:0] prevData = 8'h00;
        exp = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h66};
        set_src(2, 4'd3, 64'h332211);
        clear_logs();
        req[2] = 1'b1;
        for (int c = 0; c < 600 && !got; c++) begin
            @(posedge clk); #1;
            if (prevValid && !prevReady && (txValid !== 1'b1 || txData !== prevData)) bad++;
            if (done[2]) begin
                got    = 1'b1;
                req[2] = 1'b0;
            end
            txReady   = ($urandom_range(0, 9) < 3);
            prevValid = txValid;
            prevReady = txReady;
            prevData  = txData;
        end
        txReady = 1'b1;
        req[2]  = 1'b0;
        wait_idle();
        vectors++; if (!got) begin miscompares++; $display("[TB] FAIL stall_done got none want pulse"); end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL stall_hold got %0d changes want 0", bad); end
        vectors++; if (txq.size() != exp.size()) begin miscompares++; $display("[TB] FAIL stall_count got %0d want %0d", txq.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < txq.size(); k++) begin
            vectors++; if (txq[k] !== exp[k]) begin miscompares++; $display("[TB] FAIL stall_byte%0d got %02h want %02h", k, txq[k], exp[k]); end
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] exp[$];
        bit got = 1'b0;
        bit dropped = 1'b0;
        exp = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        set_src(3, 4'd4, 64'h04030201);
        clear_logs();
        req[3] = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(posedge clk); #1;
            if (!dropped && txq.size() >= 1) begin
                dropped = 1'b1;
                req[3]  = 1'b0;
                set_src(3, 4'd1, 64'hDEADBEEFCAFEF00D);
            end
            if (done[3]) got = 1'b1;
        end
        req[3] = 1'b0;
        wait_idle();
        vectors++; if (doneq.size() != 1 || doneq[0] !== 4'b1000) begin miscompares++; $display("[TB] FAIL snap_done got %0d pulses want 1 pulse of 1000", doneq.size()); end
        vectors++; if (txq.size() != exp.size()) begin miscompares++; $display("[TB] FAIL snap_count got %0d want %0d", txq.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < txq.size(); k++) begin
            vectors++; if (txq[k] !== exp[k]) begin miscompares++; $display("[TB] FAIL snap_byte%0d got %02h want %02h", k, txq[k], exp[k]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp[$];
        exp = '{8'hAA, 8'h10, 8'h20, 8'h30, 8'h60};
        set_src(1, 4'd3, 64'h302010);
        clear_logs();
        req[1] = 1'b1;
        for (int c = 0; c < 50 && txq.size() < 2; c++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        vectors++; if (txValid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_valid got %b want 0", txValid); end
        vectors++; if (grant !== 4'b0000) begin miscompares++; $display("[TB] FAIL midrst_grant got %b want 0000", grant); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (doneq.size() != 0) begin miscompares++; $display("[TB] FAIL midrst_done got %0d pulses want 0", doneq.size()); end
        clear_logs();
        run_frame(1);
        vectors++; if (txq.size() != exp.size()) begin miscompares++; $display("[TB] FAIL restart_count got %0d want %0d", txq.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < txq.size(); k++) begin
            vectors++; if (txq[k] !== exp[k]) begin miscompares++; $display("[TB] FAIL restart_byte%0d got %02h want %02h", k, txq[k], exp[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_latency_len0();
        test_checksum_clamp();
        test_round_robin();
        test_stall();
        test_snapshot();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
